fm_discriminator: RTL
=====================

// Module: fm_discriminator
// PURPOSE
//  Polar FM discriminator. Sits directly upstream of the 53 kHz decimating audio LPF.
//  Takes decimated baseband I/Q samples and forms z[n]*conj(z[n-1]).
//  Its angle, from an iterative CORDIC atan2, is the instantaneous frequency (MPX composite).
//  Output is an Avalon-ST style stream of signed phase-difference samples, one per accepted input.
// PARAMETERS
//  DATA_WIDTH   16  signed width of I, Q
//  PHASE_WIDTH  16  output width; +/-2^(PHASE_WIDTH-1) == +/-pi rad
//  ITERATIONS   14  CORDIC micro-rotations per sample (1..PHASE_WIDTH-1)
// PORTS
//  clk               in   1             system clock
//  reset             in   1             synchronous, active-high reset
//  ast_sink_i        in   DATA_WIDTH    signed in-phase sample
//  ast_sink_q        in   DATA_WIDTH    signed quadrature sample
//  ast_sink_valid    in   1             sample strobe, 1-cycle pulse, no backpressure
//  ast_sink_error    in   2             nonzero marks the sample as bad
//  ast_source_data   out  PHASE_WIDTH   signed phase difference (MPX)
//  ast_source_valid  out  1             1-cycle pulse per result
//  ast_source_error  out  2             {overrun_sticky, 1'b0}
// BEHAVIOUR
//  Reset: ast_source_data=0, ast_source_valid=0, ast_source_error=0.
//   Also clears i_prev/q_prev=0 and returns the FSM to IDLE.
//   Reset mid-computation aborts the computation; no output pulse follows.
//  FSM: IDLE -> MULT -> PREROT -> ITER (ITERATIONS cycles) -> OUT -> IDLE.
//  IDLE, valid & error==0: latch i,q.
//  IDLE, valid & error!=0: discard the sample; clear i_prev/q_prev to 0 (next output 0); stay IDLE.
//  MULT: xr = i*i_prev + q*q_prev; yr = q*i_prev - i*q_prev.
//   Full precision, width W = 2*DATA_WIDTH+2 (guard for CORDIC gain ~1.647).
//   i_prev/q_prev <= i/q.
//  PREROT: if xr<0, negate xr and yr; z0 = +PI when yr>=0, else -PI.
//   Otherwise z0 = 0.
//   PI = 2^(PHASE_WIDTH-1), held in a PHASE_WIDTH+1 accumulator.
//  ITER step k = 0..ITERATIONS-1:
//   if y>=0: x+=y>>>k; y-=x>>>k; z+=ATAN[k].
//   else:    x-=y>>>k; y+=x>>>k; z-=ATAN[k].
//   All updates use the old x,y.
//   ATAN[k] = round(atan(2^-k)/pi * 2^(PHASE_WIDTH-1)); e.g. 8192, 4836, 2555, ...
//  OUT: ast_source_data <= z saturated to [-2^(PHASE_WIDTH-1), 2^(PHASE_WIDTH-1)-1].
//   So +pi yields 32767. ast_source_valid=1 for exactly this cycle.
//  Latency: sample accepted on edge k -> valid high in the cycle after edge k+ITERATIONS+3.
//  Throughput: one sample per ITERATIONS+4 cycles minimum.
//  Overrun: valid while the FSM is not IDLE -> sample dropped; i_prev unchanged.
//   overrun_sticky <= 1 and stays 1 until reset. The computation in flight completes normally.
//   Valid arriving in the same cycle as OUT is also dropped.
//  xr=yr=0 (first sample after reset, zero input) -> output 0.
//  ast_source_data holds its value between pulses.
// STRUCTURE
//  Package fm_pkg:
//   - localparams PHASE_PI and the default widths
//   - function atan_lut(k, PHASE_WIDTH) generating the ATAN constants
//   - typedef of FSM state enum (IDLE, MULT, PREROT, ITER, OUT)
//  Sub-module cordic_atan2_iter:
//   - start pulse, xr/yr in; busy, done, z out
//   - contains PREROT + ITER + iteration counter
//  Top: sample latch, conjugate product, overrun logic, output register.
// TESTING
//  1. Assert reset 3 cycles -> data=0, valid=0, error=0.
//     No valid pulse for 40 cycles with sink_valid=0.
//  2. Constant I=16384, Q=0, every 20 cycles, x5 -> outputs 0,0,0,0,0.
//     Each valid exactly 17 cycles after its input.
//  3. +90 deg/sample: (16384,0),(0,16384),(-16384,0),(0,-16384) -> 0, 16384, 16384, 16384.
//     Tolerance +/-2 LSB.
//  4. (16384,0),(-16384,0) -> 0, then 32767 (yr=0 path).
//     (16384,0),(11585,-11585) -> 0, then -8192 +/-2.
//  5. Second valid 5 cycles after the first -> one output pulse only.
//     error=2'b10 until reset; the next properly spaced sample uses the first as prev.
//  6. Reset 8 cycles after an accepted valid -> no output pulse.
//     Next sample (16384,0) -> 0.
//     Input with sink_error=2'b01 -> no output pulse; following sample -> 0.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared types and constants for the polar FM discriminator.
package fm_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 16;
  localparam int unsigned PHASE_WIDTH_DEF = 16;
  localparam int unsigned ITERATIONS_DEF  = 14;
  localparam int unsigned PHASE_PI        = 2 ** (PHASE_WIDTH_DEF - 1);

  localparam real PI_REAL = 3.14159265358979323846;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MULT,
    ST_PREROT,
    ST_ITER,
    ST_OUT
  } fm_state_e;

  // atan(2^-k) scaled so that 2^(pw-1) LSB equals pi, rounded to nearest
  function automatic int atan_lut(input int k, input int pw);
    real r;
    r = $atan(2.0 ** (-k)) / PI_REAL * (2.0 ** (pw - 1));
    return int'(r);
  endfunction

endpackage

// File: rtl/cordic_atan2_iter.sv
// Vectoring-mode CORDIC atan2: half-plane pre-rotation, then one micro-rotation per cycle.
module cordic_atan2_iter
  import fm_pkg::*;
#(
  parameter int unsigned IN_W        = 34,
  parameter int unsigned PHASE_WIDTH = 16,
  parameter int unsigned ITERATIONS  = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic signed [IN_W-1:0]   xr_i,
  input  logic signed [IN_W-1:0]   yr_i,
  output logic                     busy_o,
  output logic                     done_c_o,
  output logic signed [PHASE_WIDTH:0] z_o
);

  localparam int unsigned ZW    = PHASE_WIDTH + 1;
  localparam int unsigned CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam int unsigned TAB_N = 2 ** CNT_W;
  localparam logic signed [ZW-1:0] Z_PI = ZW'(2 ** (PHASE_WIDTH - 1));

  logic signed [IN_W-1:0] x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]   z_q, z_d, atan_k;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d, hold_q, hold_d, last_c;
  logic signed [ZW-1:0]   atan_tab [TAB_N];

  for (genvar g = 0; g < TAB_N; g++) begin : g_atan
    assign atan_tab[g] = ZW'(atan_lut(g, int'(PHASE_WIDTH)));
  end

  assign atan_k   = atan_tab[cnt_q];
  assign last_c   = busy_q && (cnt_q == CNT_W'(ITERATIONS - 1));
  assign done_c_o = last_c;
  assign busy_o   = busy_q;
  assign z_o      = z_q;

  // A zero vector has no angle; hold z at 0 instead of letting it drift.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    hold_d = hold_q;
    if (start_i) begin
      cnt_d  = '0;
      busy_d = 1'b1;
      hold_d = (xr_i == '0) && (yr_i == '0);
      if (xr_i[IN_W-1]) begin
        x_d = -xr_i;
        y_d = -yr_i;
        z_d = yr_i[IN_W-1] ? -Z_PI : Z_PI;
      end else begin
        x_d = xr_i;
        y_d = yr_i;
        z_d = '0;
      end
    end else if (busy_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (last_c) begin
        busy_d = 1'b0;
      end
      if (!hold_q) begin
        if (!y_q[IN_W-1]) begin
          x_d = x_q + (y_q >>> cnt_q);
          y_d = y_q - (x_q >>> cnt_q);
          z_d = z_q + atan_k;
        end else begin
          x_d = x_q - (y_q >>> cnt_q);
          y_d = y_q + (x_q >>> cnt_q);
          z_d = z_q - atan_k;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/fm_discriminator.sv
// Polar FM discriminator: angle of z[n]*conj(z[n-1]) as a signed phase stream.
module fm_discriminator
  import fm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int unsigned ITERATIONS  = ITERATIONS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  ast_sink_i,
  input  logic [DATA_WIDTH-1:0]  ast_sink_q,
  input  logic                   ast_sink_valid,
  input  logic [1:0]             ast_sink_error,
  output logic [PHASE_WIDTH-1:0] ast_source_data,
  output logic                   ast_source_valid,
  output logic [1:0]             ast_source_error
);

  localparam int unsigned W  = 2 * DATA_WIDTH + 2;
  localparam int unsigned ZW = PHASE_WIDTH + 1;
  localparam logic signed [ZW-1:0] Z_MAX = ZW'((2 ** (PHASE_WIDTH - 1)) - 1);
  localparam logic signed [ZW-1:0] Z_MIN = ZW'(-(2 ** (PHASE_WIDTH - 1)));

  fm_state_e state_q, state_d;

  logic signed [DATA_WIDTH-1:0] s_i_q, s_i_d, s_q_q, s_q_d;
  logic signed [DATA_WIDTH-1:0] p_i_q, p_i_d, p_q_q, p_q_d;
  logic signed [W-1:0]          xr_q, xr_d, yr_q, yr_d;
  logic signed [W-1:0]          ie, qe, ipe, qpe;
  logic [PHASE_WIDTH-1:0]       data_q, data_d;
  logic                         valid_q, valid_d, ovr_q, ovr_d;
  logic                         start_c, cord_busy, cord_done_c;
  logic signed [ZW-1:0]         cord_z;

  function automatic logic [PHASE_WIDTH-1:0] sat_phase(input logic signed [ZW-1:0] z);
    if (z > Z_MAX) begin
      return PHASE_WIDTH'(Z_MAX);
    end else if (z < Z_MIN) begin
      return PHASE_WIDTH'(Z_MIN);
    end
    return PHASE_WIDTH'(z);
  endfunction

  assign ie  = W'(s_i_q);
  assign qe  = W'(s_q_q);
  assign ipe = W'(p_i_q);
  assign qpe = W'(p_q_q);

  cordic_atan2_iter #(
    .IN_W       (W),
    .PHASE_WIDTH(PHASE_WIDTH),
    .ITERATIONS (ITERATIONS)
  ) u_cordic (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_c),
    .xr_i    (xr_q),
    .yr_i    (yr_q),
    .busy_o  (cord_busy),
    .done_c_o(cord_done_c),
    .z_o     (cord_z)
  );

  // Samples arriving outside IDLE are dropped and flagged sticky.
  always_comb begin
    state_d = state_q;
    s_i_d   = s_i_q;
    s_q_d   = s_q_q;
    p_i_d   = p_i_q;
    p_q_d   = p_q_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ovr_d   = ovr_q | (ast_sink_valid && (state_q != ST_IDLE));
    start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ast_sink_valid) begin
          if (ast_sink_error == 2'b00) begin
            s_i_d   = $signed(ast_sink_i);
            s_q_d   = $signed(ast_sink_q);
            state_d = ST_MULT;
          end else begin
            p_i_d = '0;
            p_q_d = '0;
          end
        end
      end
      ST_MULT: begin
        xr_d    = ie * ipe + qe * qpe;
        yr_d    = qe * ipe - ie * qpe;
        p_i_d   = s_i_q;
        p_q_d   = s_q_q;
        state_d = ST_PREROT;
      end
      ST_PREROT: begin
        start_c = 1'b1;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        if (cord_done_c) begin
          state_d = ST_OUT;
        end else if (!cord_busy) begin
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        data_d  = sat_phase(cord_z);
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_i_q   <= '0;
      s_q_q   <= '0;
      p_i_q   <= '0;
      p_q_q   <= '0;
      xr_q    <= '0;
      yr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_i_q   <= s_i_d;
      s_q_q   <= s_q_d;
      p_i_q   <= p_i_d;
      p_q_q   <= p_q_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ast_source_data  = data_q;
  assign ast_source_valid = valid_q;
  assign ast_source_error = {ovr_q, 1'b0};

endmodule
